// File: rtl/round_sequencer.sv
// ============================================================================
//  Module   : round_sequencer
//  Purpose  : Central round controller for the pattern-memory game. Latches
//             the selected level on a start key edge, then runs every round
//             as RST -> GEN -> SHOW -> INPUT -> JUDGE (-> GAP -> RST ...),
//             counting rounds and wins until NUM_ROUNDS rounds are played.
//  Options  : ROUND_TIMEOUT_EN - when defined, the INPUT phase is closed as
//             a lost round after TIMEOUT_CYCLES cycles without inp_done.
//  Ports    :
//    clk          in   system clock (1 kHz domain)
//    rst          in   asynchronous active-low reset
//    level[2:0]   in   one-hot level (001 / 010 / 100)
//    level_valid  in   level is stable and may be latched
//    start        in   start key, level-sensitive, edge-detected here
//    gen_done     in   pattern generator finished
//    show_done    in   pattern display finished
//    inp_done     in   input trim finished
//    round_win    in   comparator verdict, valid with inp_done
//    sub_rst_n    out  active-low round-local reset for the sub-blocks
//    gen_en       out  generator enable
//    show_en      out  display enable
//    inp_en       out  input-trim enable
//    lv_mask      out  active pattern slots for the latched level
//    round_count  out  rounds completed
//    answer_count out  rounds won
//    score        out  10 * answer_count, latched at game end
//    game_end     out  game finished
//    state_dbg    out  current state encoding
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_sequencer #(
  parameter int NUM_ROUNDS     = 10,
  parameter int RST_PULSE      = 2,
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  level,
  input  logic        level_valid,
  input  logic        start,
  input  logic        gen_done,
  input  logic        show_done,
  input  logic        inp_done,
  input  logic        round_win,
  output logic        sub_rst_n,
  output logic        gen_en,
  output logic        show_en,
  output logic        inp_en,
  output logic [15:0] lv_mask,
  output logic [4:0]  round_count,
  output logic [4:0]  answer_count,
  output logic [6:0]  score,
  output logic        game_end,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_GEN   = 3'd2,
    S_SHOW  = 3'd3,
    S_INPUT = 3'd4,
    S_JUDGE = 3'd5,
    S_GAP   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        start_q;
  logic        start_edge;
  logic        level_ok;
  logic [15:0] mask_sel;
  logic [15:0] dwell_cnt;
  logic        rst_last;
  logic        gap_last;
  logic        win_q;
  logic        timeout_hit;
  logic [5:0]  rounds_next;
  logic [4:0]  answers_next;
  logic [8:0]  score_full;
  logic        sub_rst_n_nxt;
  logic        gen_en_nxt;
  logic        show_en_nxt;
  logic        inp_en_nxt;
  logic        game_end_nxt;

  assign start_edge = start & ~start_q;
  assign level_ok   = level_valid &
                      ((level == 3'b001) | (level == 3'b010) | (level == 3'b100));
  assign state_dbg  = state;

  // Dwell counter is only meaningful in RST and GAP; it restarts on entry.
  assign rst_last = (dwell_cnt == 16'(RST_PULSE - 1));
  assign gap_last = (dwell_cnt == 16'(GAP_CYCLES - 1));

  assign rounds_next  = {1'b0, round_count} + 6'd1;
  assign answers_next = answer_count + {4'b0, win_q};
  assign score_full   = {4'b0, answers_next} * 9'd10;

  always_comb begin
    mask_sel = 16'h0000;
    case (level)
      3'b001:  mask_sel = 16'h00FF;
      3'b010:  mask_sel = 16'h0FFF;
      3'b100:  mask_sel = 16'hFFFF;
      default: mask_sel = 16'h0000;
    endcase
  end

`ifdef ROUND_TIMEOUT_EN
  logic [13:0] to_cnt;

  // Counts cycles spent in INPUT; cleared in every other state so that it
  // starts from zero on each INPUT entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= 14'd0;
    end else if (state != S_INPUT) begin
      to_cnt <= 14'd0;
    end else begin
      to_cnt <= to_cnt + 14'd1;
    end
  end

  assign timeout_hit = (state == S_INPUT) && (to_cnt == 14'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_edge && level_ok) state_nxt = S_RST;
      S_RST:   if (rst_last) state_nxt = S_GEN;
      // A done input only counts while its block has actually been enabled.
      S_GEN:   if (gen_en && gen_done) state_nxt = S_SHOW;
      S_SHOW:  if (show_en && show_done) state_nxt = S_INPUT;
      S_INPUT: if ((inp_en && inp_done) || timeout_hit) state_nxt = S_JUDGE;
      S_JUDGE: state_nxt = (rounds_next >= 6'(NUM_ROUNDS)) ? S_DONE : S_GAP;
      S_GAP:   if (gap_last) state_nxt = S_RST;
      S_DONE:  if (start_edge) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // An enable rises one cycle after its state is entered and drops on the
    // same edge the state is left, so it never overlaps another phase.
    gen_en_nxt    = (state == S_GEN)   && (state_nxt == S_GEN);
    show_en_nxt   = (state == S_SHOW)  && (state_nxt == S_SHOW);
    inp_en_nxt    = (state == S_INPUT) && (state_nxt == S_INPUT);
    sub_rst_n_nxt = (state_nxt != S_IDLE) && (state_nxt != S_RST) &&
                    (state_nxt != S_DONE);
    game_end_nxt  = (state_nxt == S_DONE);
  end

  // Registered outputs, counters and round bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q      <= 1'b0;
      dwell_cnt    <= 16'd0;
      win_q        <= 1'b0;
      sub_rst_n    <= 1'b0;
      gen_en       <= 1'b0;
      show_en      <= 1'b0;
      inp_en       <= 1'b0;
      game_end     <= 1'b0;
      lv_mask      <= 16'h0000;
      round_count  <= 5'd0;
      answer_count <= 5'd0;
      score        <= 7'd0;
    end else begin
      start_q   <= start;
      sub_rst_n <= sub_rst_n_nxt;
      gen_en    <= gen_en_nxt;
      show_en   <= show_en_nxt;
      inp_en    <= inp_en_nxt;
      game_end  <= game_end_nxt;

      if (((state == S_RST) || (state == S_GAP)) && (state_nxt == state)) begin
        dwell_cnt <= dwell_cnt + 16'd1;
      end else begin
        dwell_cnt <= 16'd0;
      end

      if ((state == S_IDLE) && (state_nxt == S_RST)) begin
        lv_mask      <= mask_sel;
        round_count  <= 5'd0;
        answer_count <= 5'd0;
        score        <= 7'd0;
      end

      // A timeout leaves INPUT without inp_done, which forces a lost round.
      if ((state == S_INPUT) && (state_nxt == S_JUDGE)) begin
        win_q <= inp_en & inp_done & round_win;
      end

      if (state == S_JUDGE) begin
        if (round_count != 5'(NUM_ROUNDS)) begin
          round_count <= round_count + 5'd1;
        end
        answer_count <= answers_next;
        if (state_nxt == S_DONE) begin
          score <= (score_full > 9'd127) ? 7'd127 : score_full[6:0];
        end
      end

      if ((state == S_DONE) && (state_nxt == S_IDLE)) begin
        round_count  <= 5'd0;
        answer_count <= 5'd0;
        score        <= 7'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_round_sequencer.sv
// ============================================================================
//  Module   : tb_round_sequencer
//  Purpose  : Directed, self-checking bench for round_sequencer. A game-level
//             model (mask, rounds played, rounds won, end flag, score) is
//             updated by the stimulus tasks and compared on every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_round_sequencer;

  localparam int NR = 10;

  logic        clk;
  logic        rst;
  logic [2:0]  level;
  logic        level_valid;
  logic        start;
  logic        gen_done;
  logic        show_done;
  logic        inp_done;
  logic        round_win;
  logic        sub_rst_n;
  logic        gen_en;
  logic        show_en;
  logic        inp_en;
  logic [15:0] lv_mask;
  logic [4:0]  round_count;
  logic [4:0]  answer_count;
  logic [6:0]  score;
  logic        game_end;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Game-level model
  logic [15:0] m_mask = 16'h0000;
  int          m_rounds = 0;
  int          m_wins = 0;
  int          m_score = 0;
  bit          m_end = 1'b0;

  round_sequencer #(
    .NUM_ROUNDS     (NR),
    .RST_PULSE      (2),
    .GAP_CYCLES     (3),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .level        (level),
    .level_valid  (level_valid),
    .start        (start),
    .gen_done     (gen_done),
    .show_done    (show_done),
    .inp_done     (inp_done),
    .round_win    (round_win),
    .sub_rst_n    (sub_rst_n),
    .gen_en       (gen_en),
    .show_en      (show_en),
    .inp_en       (inp_en),
    .lv_mask      (lv_mask),
    .round_count  (round_count),
    .answer_count (answer_count),
    .score        (score),
    .game_end     (game_end),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic model_judge(input logic win);
    if (m_rounds < NR) m_rounds++;
    m_wins += int'(win);
    if (m_rounds == NR) begin
      m_end   = 1'b1;
      m_score = 10 * m_wins;
    end
  endtask

  task automatic model_clear_game();
    m_rounds = 0;
    m_wins   = 0;
    m_score  = 0;
    m_end    = 1'b0;
  endtask

  function automatic logic en_sel(input int which);
    case (which)
      0:       return gen_en;
      1:       return show_en;
      default: return inp_en;
    endcase
  endfunction

  task automatic wait_en(input int which, input string name);
    int n = 0;
    while (!en_sel(which) && n < 300) begin
      step();
      n++;
    end
    chk(name, int'(en_sel(which)), 1);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while (state_dbg != s && n < 300) begin
      step();
      n++;
    end
    chk(name, int'(state_dbg), int'(s));
  endtask

  // Runs one round from wherever the DUT is (JUDGE, IDLE->RST, or GEN).
  task automatic run_round(input logic win, input bit spurious,
                           input bit timing, input bit tmo);
    int n     = 0;
    int low_n = 0;
    int gap_n = 0;
    while (state_dbg != 3'd2 && n < 300) begin
      if (!sub_rst_n) low_n++;
      if (state_dbg == 3'd6) gap_n++;
      step();
      n++;
    end
    chk("reach_gen", int'(state_dbg), 2);
    if (timing) begin
      chk("sub_rst_low_cycles", low_n, 2);
      chk("gap_cycles", gap_n, 3);
      chk("gen_en_at_entry", int'(gen_en), 0);
      step();
      chk("gen_en_one_after_entry", int'(gen_en), 1);
    end
    wait_en(0, "gen_en_wait");
    if (spurious) begin
      show_done = 1'b1;
      step();
      show_done = 1'b0;
      chk("spurious_show_done_state", int'(state_dbg), 2);
      chk("spurious_show_done_en", int'(show_en), 0);
    end
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
    chk("gen_to_show", int'(state_dbg), 3);
    wait_en(1, "show_en_wait");
    show_done = 1'b1;
    step();
    show_done = 1'b0;
    chk("show_to_input", int'(state_dbg), 4);
    if (tmo) begin
`ifdef ROUND_TIMEOUT_EN
      begin
        int cnt = 1;
        int k   = 0;
        while (state_dbg == 3'd4 && k < 100) begin
          step();
          k++;
          if (state_dbg == 3'd4) cnt++;
        end
        chk("timeout_input_cycles", cnt, 20);
        chk("timeout_to_judge", int'(state_dbg), 5);
        model_judge(1'b0);
      end
`else
      wait_en(2, "inp_en_wait");
      repeat (30) step();
      chk("input_waits_forever", int'(state_dbg), 4);
      round_win = 1'b1;
      inp_done  = 1'b1;
      step();
      inp_done  = 1'b0;
      round_win = 1'b0;
      chk("input_to_judge", int'(state_dbg), 5);
      model_judge(1'b1);
`endif
    end else begin
      wait_en(2, "inp_en_wait");
      if (spurious) begin
        start = 1'b1;
        step();
        start = 1'b0;
        chk("spurious_start_in_input", int'(state_dbg), 4);
      end
      round_win = win;
      inp_done  = 1'b1;
      step();
      inp_done  = 1'b0;
      round_win = 1'b0;
      chk("input_to_judge", int'(state_dbg), 5);
      model_judge(win);
    end
  endtask

  // Cycle-by-cycle comparison against the model. Counters settle one cycle
  // after the verdict, so JUDGE itself is not compared for them.
  always @(negedge clk) begin
    if (state_dbg != 3'd5) begin
      chk("lv_mask", int'(lv_mask), int'(m_mask));
      chk("round_count", int'(round_count), m_rounds);
      chk("answer_count", int'(answer_count), m_wins);
      chk("score", int'(score), m_score);
      chk("game_end", int'(game_end), int'(m_end));
    end
    chk("sub_rst_n_vs_state", int'(sub_rst_n),
        int'(state_dbg >= 3'd2 && state_dbg <= 3'd6));
    chk("enables_exclusive",
        int'(int'(gen_en) + int'(show_en) + int'(inp_en) <= 1), 1);
    if (gen_en)  chk("gen_en_only_in_gen", int'(state_dbg), 2);
    if (show_en) chk("show_en_only_in_show", int'(state_dbg), 3);
    if (inp_en)  chk("inp_en_only_in_input", int'(state_dbg), 4);
  end

  logic [2:0] bad_lvl [3] = '{3'b000, 3'b011, 3'b010};
  logic       bad_vld [3] = '{1'b1, 1'b1, 1'b0};
  logic       wins    [NR] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst         = 1'b0;
    level       = 3'b000;
    level_valid = 1'b0;
    start       = 1'b0;
    gen_done    = 1'b0;
    show_done   = 1'b0;
    inp_done    = 1'b0;
    round_win   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", int'(state_dbg), 0);
    chk("reset_sub_rst_n", int'(sub_rst_n), 0);
    chk("reset_lv_mask", int'(lv_mask), 0);
    chk("reset_gen_en", int'(gen_en), 0);
    rst = 1'b1;
    step();

    // Rejected starts: zero level, non-one-hot level, level not yet valid
    for (int i = 0; i < 3; i++) begin
      level       = bad_lvl[i];
      level_valid = bad_vld[i];
      start       = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("bad_start_stays_idle", int'(state_dbg), 0);
      chk("bad_start_mask_zero", int'(lv_mask), 0);
    end

    // Game 1: level 010, start held 50 cycles
    level       = 3'b010;
    level_valid = 1'b1;
    start       = 1'b1;
    step();
    m_mask = 16'h0FFF;
    chk("start_accepted", int'(state_dbg), 1);
    chk("lv_mask_level2", int'(lv_mask), 16'h0FFF);
    repeat (49) step();
    start = 1'b0;
    step();
    chk("held_start_one_round", int'(state_dbg), 2);
    chk("held_start_round_count", int'(round_count), 0);

    for (int i = 0; i < NR; i++) begin
      run_round(wins[i], i == 2, i == 1, 1'b0);
    end
    step();
    chk("no_gap_after_last", int'(state_dbg), 7);
    chk("final_round_count", int'(round_count), 10);
    chk("final_answer_count", int'(answer_count), 6);
    chk("final_game_end", int'(game_end), 1);
    chk("final_score", int'(score), 60);

    // DONE -> IDLE on a new start edge, mask held
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear_game();
    chk("done_to_idle", int'(state_dbg), 0);
    chk("mask_held_in_idle", int'(lv_mask), 16'h0FFF);
    step();

    // Game 2: level 100; level change mid-game must be ignored
    level = 3'b100;
    start = 1'b1;
    step();
    start = 1'b0;
    m_mask = 16'hFFFF;
    chk("lv_mask_level3", int'(lv_mask), 16'hFFFF);
    level = 3'b001;
    run_round(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of GEN
    wait_state(3'd2, "reach_gen_round2");
    wait_en(0, "gen_en_before_reset");
    rst = 1'b0;
    m_mask = 16'h0000;
    model_clear_game();
    #1;
    chk("async_rst_sub_rst_n", int'(sub_rst_n), 0);
    chk("async_rst_gen_en", int'(gen_en), 0);
    chk("async_rst_round_count", int'(round_count), 0);
    step();
    chk("rst_state_idle", int'(state_dbg), 0);
    rst = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Central round controller for the pattern-memory game.
- Takes the selected level and the start key, then runs each round in order: pattern generation, then pattern display, then button input, then judging.
- Drives the enable and round-local reset lines of the generator, display and input-trim blocks.
- Keeps round and answer counters, produces the level mask and final score, and asserts game end after NUM_ROUNDS rounds.

Parameters:
- NUM_ROUNDS, 10, rounds per game (1..31).
- RST_PULSE, 2, clk cycles sub_rst_n is held low before each round (>=1).
- GAP_CYCLES, 3, idle cycles between judge and the next round's reset (>=1).
- TIMEOUT_CYCLES, 10000, input-phase cycle limit; used only with ROUND_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (1 kHz domain)
- rst  in  1  asynchronous active-low reset
- level  in  3  one-hot level from level select: 001 / 010 / 100
- level_valid  in  1  level select finished; level is stable
- start  in  1  start key (keypad 0), level-sensitive, synchronous to clk
- gen_done  in  1  pattern generator finished
- show_done  in  1  pattern display finished
- inp_done  in  1  input trim finished
- round_win  in  1  comparator result, valid while inp_done=1
- sub_rst_n  out  1  active-low round-local reset to generator, display and input-trim blocks
- gen_en  out  1  generator enable
- show_en  out  1  display enable
- inp_en  out  1  input-trim enable
- lv_mask  out  16  active pattern slots
- round_count  out  5  rounds completed
- answer_count  out  5  rounds won
- score  out  7  10*answer_count, latched at game end
- game_end  out  1  game finished
- state_dbg  out  3  current state encoding

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all counters=0; lv_mask=0; score=0.
  - gen_en, show_en, inp_en and game_end=0; sub_rst_n=0.
- Start detection: start_edge = start & ~start_q, where start_q is a registered copy of start. A start held high is one edge only.
- States and encoding: IDLE=0, RST=1, GEN=2, SHOW=3, INPUT=4, JUDGE=5, GAP=6, DONE=7.
- IDLE:
  - sub_rst_n=0.
  - On start_edge & level_valid & level ∈ {001, 010, 100}:
    - latch lv_mask: 001→0x00FF, 010→0x0FFF, 100→0xFFFF.
    - clear the counters and go to RST.
  - Invalid or zero level: start_edge is ignored and the state stays IDLE.
- RST: sub_rst_n=0 for exactly RST_PULSE cycles, then GEN.
- GEN: sub_rst_n=1, gen_en=1. First cycle gen_done=1 → SHOW. gen_en stays high through that cycle.
- SHOW: show_en=1 until show_done=1 → INPUT.
- INPUT: inp_en=1 until inp_done=1 → JUDGE. round_win is sampled on the same edge into a register.
- JUDGE: one cycle.
  - round_count += 1; answer_count += the sampled win.
  - If the new round_count == NUM_ROUNDS → DONE, else → GAP.
- GAP: all enables 0, sub_rst_n=1, GAP_CYCLES cycles, then → RST.
- DONE:
  - game_end=1; score=10*answer_count, registered on entry.
  - sub_rst_n=0; all enables 0.
  - start_edge → IDLE: counters, score and game_end cleared; lv_mask held.
- Enables are registered outputs: one cycle from state entry to enable high. At most one enable is high at any time.
- A done input arriving while its phase is inactive is ignored. gen_en, show_en and inp_en are never high outside their own state.
- start_edge in RST through GAP is ignored; no abort. Changes on level after latching are ignored until IDLE.
- Counters saturate: round_count never exceeds NUM_ROUNDS; score is at most 100 for NUM_ROUNDS=10, 7 bits wide.
- rst going low mid-round returns to IDLE immediately, with all outputs at their reset values.

Optional Feature:
- ROUND_TIMEOUT_EN defined:
  - A 14-bit counter runs in INPUT.
  - When it reaches TIMEOUT_CYCLES without inp_done → JUDGE with the win forced to 0.
  - The counter clears on INPUT entry.
- Undefined: INPUT waits indefinitely; there is no timeout counter.

Test Plan:
- Reset mid-GEN: rst low → within the same cycle sub_rst_n=0 and gen_en=0; next edge state_dbg=0; all counters 0.
- Level 010 with level_valid, start pulse:
  - lv_mask=0x0FFF.
  - sub_rst_n low exactly 2 cycles.
  - gen_en high 1 cycle after GEN entry.
  - The phases chain on gen_done, show_done and inp_done, each driven 1 cycle high.
- Full game, NUM_ROUNDS=10, round_win=1 on rounds 1, 3, 4, 7, 9, 10:
  - round_count=10, answer_count=6.
  - game_end=1, score=60.
  - No GAP after round 10.
- Start with level=000 or 011, or with level_valid=0 → state stays IDLE, lv_mask=0. A start held high 50 cycles → exactly one round begins.
- Spurious inputs: show_done pulsed during GEN → ignored, state stays GEN. start pulsed during INPUT → ignored.
- With ROUND_TIMEOUT_EN and TIMEOUT_CYCLES=20: no inp_done → JUDGE after 20 INPUT cycles; answer_count unchanged; round_count +1.
